// File: rtl/lab2_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : lab2_sweep_if
// Description : Control, feedback and result bundle of the truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
interface lab2_sweep_if;
    logic       start;
    logic       abort;
    logic       X_in;
    logic       Y_in;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_cnt;
    logic [2:0] first_fail;
    logic [7:0] x_log;
    logic [7:0] y_log;

    // master: the sweeper itself; slave: whoever requests sweeps and closes the loop
    modport master (
        input  start, abort, X_in, Y_in,
        output A, B, C, busy, done, pass, fail_cnt, first_fail, x_log, y_log
    );
    modport slave (
        output start, abort, X_in, Y_in,
        input  A, B, C, busy, done, pass, fail_cnt, first_fail, x_log, y_log
    );
endinterface
`default_nettype wire

// File: rtl/lab2_sweep.sv
`default_nettype none
// ============================================================================
// Module      : lab2_sweep
// Description : Walks {A,B,C} through 0..7, samples X/Y back after a settle
//               time and checks them against expected truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
module lab2_sweep #(
    parameter int         SETTLE = 2,
    parameter logic [7:0] EXP_X  = 8'h49,
    parameter logic [7:0] EXP_Y  = 8'hC6
) (
    input  logic         clk,
    input  logic         rst_n,
    lab2_sweep_if.master bus
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DRIVE    = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE   = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] c_FAIL_MAX    = 4'd8;

    logic [1:0] r_state;
    logic [2:0] r_idx;
    logic [3:0] r_settle;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_fail_cnt;
    logic [2:0] r_first_fail;
    logic [7:0] r_x_log;
    logic [7:0] r_y_log;

    logic       w_mismatch;
    logic [3:0] w_fail_cnt_nxt;

    assign w_mismatch = (bus.X_in != EXP_X[r_idx]) || (bus.Y_in != EXP_Y[r_idx]);

    always_comb begin
        w_fail_cnt_nxt = r_fail_cnt;
        if (w_mismatch && (r_fail_cnt != c_FAIL_MAX)) begin
            w_fail_cnt_nxt = r_fail_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= 3'd0;
            r_settle     <= 4'd0;
            r_abc        <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_cnt   <= 4'd0;
            r_first_fail <= 3'd0;
            r_x_log      <= 8'd0;
            r_y_log      <= 8'd0;
        end else if (bus.abort) begin
            // Results gathered so far stay visible after a cancel
            r_state  <= c_ST_IDLE;
            r_settle <= 4'd0;
            r_abc    <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_state      <= c_ST_DRIVE;
                        r_idx        <= 3'd0;
                        r_settle     <= 4'd0;
                        r_abc        <= 3'd0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail_cnt   <= 4'd0;
                        r_first_fail <= 3'd0;
                        r_x_log      <= 8'd0;
                        r_y_log      <= 8'd0;
                    end
                end
                c_ST_DRIVE: begin
                    r_settle <= r_settle + 4'd1;
                    if (r_settle == c_SETTLE_LAST) begin
                        r_state <= c_ST_SAMPLE;
                    end
                end
                c_ST_SAMPLE: begin
                    r_x_log[r_idx] <= bus.X_in;
                    r_y_log[r_idx] <= bus.Y_in;
                    r_fail_cnt     <= w_fail_cnt_nxt;
                    if (w_mismatch && (r_fail_cnt == 4'd0)) begin
                        r_first_fail <= r_idx;
                    end
                    if (r_idx == 3'd7) begin
                        r_state <= c_ST_DONE;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_cnt_nxt == 4'd0);
                    end else begin
                        r_state  <= c_ST_DRIVE;
                        r_idx    <= r_idx + 3'd1;
                        r_abc    <= r_idx + 3'd1;
                        r_settle <= 4'd0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.A          = r_abc[2];
    assign bus.B          = r_abc[1];
    assign bus.C          = r_abc[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.fail_cnt   = r_fail_cnt;
    assign bus.first_fail = r_first_fail;
    assign bus.x_log      = r_x_log;
    assign bus.y_log      = r_y_log;

endmodule
`default_nettype wire

// File: tb/tb_lab2_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab2_sweep
// Description : Closes two sweepers over table-driven stages and checks their
//               results against a truth-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab2_sweep;

    localparam logic [7:0] c_EX0 = 8'h49;
    localparam logic [7:0] c_EY0 = 8'hC6;
    localparam logic [7:0] c_EX1 = 8'h96;
    localparam logic [7:0] c_EY1 = 8'h0F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx0, ty0, tx1, ty1;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    lab2_sweep_if bus0 ();
    lab2_sweep_if bus1 ();

    // The stage under observation is simply a pair of lookup tables
    assign bus0.X_in = tx0[{bus0.A, bus0.B, bus0.C}];
    assign bus0.Y_in = ty0[{bus0.A, bus0.B, bus0.C}];
    assign bus1.X_in = tx1[{bus1.A, bus1.B, bus1.C}];
    assign bus1.Y_in = ty1[{bus1.A, bus1.B, bus1.C}];

    lab2_sweep #(.SETTLE(2), .EXP_X(c_EX0), .EXP_Y(c_EY0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    lab2_sweep #(.SETTLE(1), .EXP_X(c_EX1), .EXP_Y(c_EY1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // {abc[28:26], busy[25], done[24], pass[23], fail_cnt[22:19], first_fail[18:16], x_log[15:8], y_log[7:0]}
    logic [28:0] obs0, obs1;
    assign obs0 = {bus0.A, bus0.B, bus0.C, bus0.busy, bus0.done, bus0.pass,
                   bus0.fail_cnt, bus0.first_fail, bus0.x_log, bus0.y_log};
    assign obs1 = {bus1.A, bus1.B, bus1.C, bus1.busy, bus1.done, bus1.pass,
                   bus1.fail_cnt, bus1.first_fail, bus1.x_log, bus1.y_log};

    function automatic logic [28:0] obs(input int sel);
        return (sel != 0) ? obs1 : obs0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) bus1.start = v; else bus0.start = v;
    endtask

    // Reference: mismatch count and lowest mismatching index over idx < upto
    task automatic expect_res(input int sel, input logic [7:0] tx, input logic [7:0] ty,
                              input int upto, output int fc, output int ff);
        logic [7:0] ex, ey;
        ex = (sel != 0) ? c_EX1 : c_EX0;
        ey = (sel != 0) ? c_EY1 : c_EY0;
        fc = 0;
        ff = 0;
        for (int i = 0; i < upto; i++) begin
            if ((tx[i] != ex[i]) || (ty[i] != ey[i])) begin
                if (fc == 0) ff = i;
                fc++;
            end
        end
        if (fc > 8) fc = 8;
    endtask

    task automatic sweep(input int sel, input logic [7:0] tx, input logic [7:0] ty, input string tag);
        int          s, len, n, fc, ff;
        logic [28:0] o;
        s   = (sel != 0) ? 1 : 2;
        len = 8 * (s + 1);
        if (sel != 0) begin tx1 = tx; ty1 = ty; end
        else          begin tx0 = tx; ty0 = ty; end
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        o = obs(sel);
        chk({tag, "_clr_logs"}, 32'(o[15:0]), 32'd0);
        chk({tag, "_clr_cnt"}, 32'(o[22:16]), 32'd0);
        chk({tag, "_clr_done_pass"}, 32'(o[24:23]), 32'd0);
        n = 0;
        while ((o[24] == 1'b0) && (n < len + 4)) begin
            chk({tag, "_abc"}, 32'(o[28:26]), 32'(n / (s + 1)));
            chk({tag, "_busy"}, 32'(o[25]), 32'd1);
            tick();
            n++;
            o = obs(sel);
        end
        expect_res(sel, tx, ty, 8, fc, ff);
        chk({tag, "_latency"}, 32'(n), 32'(len));
        chk({tag, "_done"}, 32'(o[24]), 32'd1);
        chk({tag, "_busy_end"}, 32'(o[25]), 32'd0);
        chk({tag, "_abc_end"}, 32'(o[28:26]), 32'd0);
        chk({tag, "_pass"}, 32'(o[23]), 32'(fc == 0));
        chk({tag, "_fail_cnt"}, 32'(o[22:19]), 32'(fc));
        chk({tag, "_first_fail"}, 32'(o[18:16]), 32'(ff));
        chk({tag, "_x_log"}, 32'(o[15:8]), 32'(tx));
        chk({tag, "_y_log"}, 32'(o[7:0]), 32'(ty));
        tick();
        tick();
        o = obs(sel);
        chk({tag, "_hold_done_pass"}, 32'(o[24:23]), {30'd0, 1'b1, (fc == 0)});
    endtask

    initial begin
        int          fc, ff;
        logic [7:0]  rx, ry;
        logic [28:0] o;
        logic        seen;

        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        tx0 = c_EX0; ty0 = c_EY0; tx1 = c_EX1; ty1 = c_EY1;
        repeat (2) tick();
        chk("reset_dut0", 32'(obs0), 32'd0);
        chk("reset_dut1", 32'(obs1), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_after_reset", 32'(obs0), 32'd0);

        // Directed feedback patterns
        sweep(0, c_EX0, c_EY0, "golden");
        sweep(0, c_EX0, 8'h00, "y_stuck0");
        sweep(0, ~c_EX0, ~c_EY0, "inverted");
        for (int k = 0; k < 4; k++) sweep(0, 8'($urandom()), 8'($urandom()), "rand0");

        // SETTLE=1 instance; back-to-back sweeps restart straight out of DONE
        sweep(1, c_EX1, c_EY1, "d1_golden");
        for (int k = 0; k < 3; k++) sweep(1, 8'($urandom()), 8'($urandom()), "rand1");

        // Abort in DRIVE at idx 3
        rx = 8'($urandom()); ry = 8'($urandom());
        tx0 = rx; ty0 = ry;
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        repeat (9) tick();
        chk("abort_pre_abc", 32'(obs0[28:26]), 32'd3);
        bus0.abort = 1'b1; tick(); bus0.abort = 1'b0;
        o = obs0;
        expect_res(0, rx, ry, 3, fc, ff);
        chk("abort_ctrl", 32'(o[28:23]), 32'd0);
        chk("abort_x_log", 32'(o[15:8]), {29'd0, rx[2:0]});
        chk("abort_y_log", 32'(o[7:0]), {29'd0, ry[2:0]});
        chk("abort_fail_cnt", 32'(o[22:19]), 32'(fc));
        chk("abort_first_fail", 32'(o[18:16]), 32'(ff));
        repeat (3) tick();
        chk("abort_stays_idle", 32'(obs0[25:24]), 32'd0);
        sweep(0, c_EX0, c_EY0, "post_abort");

        // Abort and start together while in DONE: abort wins, logs kept
        bus0.start = 1'b1; bus0.abort = 1'b1; tick();
        bus0.start = 1'b0; bus0.abort = 1'b0;
        chk("abort_start_ctrl", 32'(obs0[25:23]), 32'd0);
        chk("abort_start_x_log", 32'(obs0[15:8]), 32'(c_EX0));
        tick();
        chk("abort_start_no_run", 32'(obs0[25]), 32'd0);

        // Restart attempt at idx 4 is ignored, then reset at idx 5
        rx = 8'($urandom()); ry = 8'($urandom());
        tx0 = rx; ty0 = ry;
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        repeat (12) tick();
        chk("restart_pre_abc", 32'(obs0[28:26]), 32'd4);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        chk("restart_ignored_abc", 32'(obs0[28:26]), 32'd4);
        chk("restart_ignored_busy", 32'(obs0[25]), 32'd1);
        chk("restart_ignored_x_log", 32'(obs0[11:8]), 32'(rx[3:0]));
        repeat (2) tick();
        chk("pre_reset_abc", 32'(obs0[28:26]), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_all", 32'(obs0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs0[25:24] != 2'b00) seen = 1'b1;
        end
        chk("no_run_after_reset", 32'(seen), 32'd0);
        sweep(0, c_EX0, c_EY0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab2_sweep.md
LAB2_SWEEP -- requirements
Module: lab2_sweep

Purpose: upstream stimulus and downstream checker for the three-input, two-output combinational stage. It drives A/B/C through all 8 combinations, samples X/Y back, and checks them against expected truth tables.

Interface
REQ-001 Parameter SETTLE, default 2: cycles each combination is held before sampling; legal range 1..15.
REQ-002 Parameter EXP_X, default 8'h49: expected X; bit i corresponds to {A,B,C}==i.
REQ-003 Parameter EXP_Y, default 8'hC6: expected Y; same bit indexing as EXP_X.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle sweep request.
REQ-008 abort  in  1  synchronous sweep cancel.
REQ-009 X_in  in  1  X returned from the combinational stage.
REQ-010 Y_in  in  1  Y returned from the combinational stage.
REQ-011 A, B, C  out  1 each  registered stimulus; {A,B,C} equals the index idx.
REQ-012 busy  out  1  high during DRIVE or SAMPLE.
REQ-013 done  out  1  high in state DONE.
REQ-014 pass  out  1  valid while done; 1 when there were no mismatches.
REQ-015 fail_cnt  out  4  mismatch count, range 0..8.
REQ-016 first_fail  out  3  lowest mismatching idx; 0 if there was no mismatch.
REQ-017 x_log, y_log  out  8 each  captured X/Y; bit i holds the sample taken at idx i.

Function
REQ-018 The FSM SHALL have four states (IDLE, DRIVE, SAMPLE, DONE), a 3-bit idx and a 4-bit settle counter.
REQ-019 IDLE or DONE, start=1 and abort=0: next state DRIVE; idx, counters, fail_cnt, first_fail, x_log and y_log cleared; pass=0.
REQ-020 DRIVE: the settle counter increments each cycle; after SETTLE cycles in DRIVE the FSM goes to SAMPLE.
REQ-021 SAMPLE lasts one cycle; x_log[idx]<=X_in and y_log[idx]<=Y_in.
REQ-022 SAMPLE mismatch (X_in!=EXP_X[idx] or Y_in!=EXP_Y[idx]): fail_cnt increments; first_fail<=idx on the first mismatch only.
REQ-023 SAMPLE with idx<7: idx+1, settle counter cleared, next state DRIVE.
REQ-024 SAMPLE with idx==7: next state DONE; idx stays 7 (no wrap); pass<=1 when the final fail_cnt is 0, including the current sample.
REQ-025 {A,B,C} SHALL equal idx in DRIVE and SAMPLE, and be 3'b000 in IDLE and DONE.
REQ-026 Latency: with start sampled at edge k, done SHALL rise at edge k+8*(SETTLE+1); 24 cycles with SETTLE=2.
REQ-027 done and pass SHALL hold in DONE until the next accepted start, abort, or reset.
REQ-028 start while busy SHALL be ignored, with no restart and no effect on the logs.
REQ-029 abort=1 in any state SHALL go to IDLE next cycle with done=0, busy=0 and pass=0; x_log, y_log, fail_cnt and first_fail keep their values.
REQ-030 When abort and start are asserted in the same cycle, abort SHALL win.
REQ-031 fail_cnt SHALL saturate at 8 and never wrap.
REQ-032 All outputs SHALL be registered, with no combinational path from X_in/Y_in to any output.

Reset
REQ-033 rst_n=0 SHALL force, immediately and asynchronously: state IDLE; A=B=C=0; busy, done and pass 0; fail_cnt, first_fail, x_log, y_log and idx all 0.
REQ-034 A reset mid-sweep SHALL discard the sweep; after release a new start is required.
REQ-035 Deassertion of reset is synchronous to clk; the first transition out of IDLE occurs no earlier than the first edge after release.

Verification
REQ-036 Golden feedback (X_in/Y_in computed from EXP_X/EXP_Y at the current {A,B,C}), SETTLE=2, start pulse -> done at +24 cycles, pass=1, fail_cnt=0, x_log=8'h49, y_log=8'hC6.
REQ-037 Golden X, Y_in stuck at 0 -> fail_cnt=4, first_fail=1, y_log=8'h00, pass=0.
REQ-038 Both inputs inverted -> fail_cnt=8 (saturated), first_fail=0, x_log=8'hB6, y_log=8'h39.
REQ-039 Abort during DRIVE at idx=3 -> IDLE next cycle, A/B/C=000, x_log bits 0..2 retained; a new start then gives a full pass.
REQ-040 Second start at idx=4, then rst_n low at idx=5 -> the second start has no effect; all outputs are 0 asynchronously; no done until a fresh start completes.
REQ-041 Start held during DONE for one cycle -> logs cleared, A/B/C=000, busy next cycle; the SETTLE=1 sweep finishes in 16 cycles.
